fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the lab processor. It merges the address counter and instruction memory into one block on a single clock. A load mode fills memory word by word from the switches. A run mode streams instructions to the processor over a valid/ready handshake, with jump redirect and end-of-program handling.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bus between the instruction-fetch front end and its environment.
// Load side (LoadMode/WrEn/WrData/WrAddr) and run-side fetch handshake.
interface fetch_unit_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
);
   logic              LoadMode;
   logic              WrEn;
   logic [DATA_W-1:0] WrData;
   logic              Run;
   logic              Ready;
   logic              JumpEn;
   logic [ADDR_W-1:0] JumpAddr;
   logic              Valid;
   logic [DATA_W-1:0] Instr;
   logic [ADDR_W-1:0] InstrAddr;
   logic [ADDR_W-1:0] WrAddr;
   logic              Halted;

   // Handshake: a word transfers on every rising edge where Valid && Ready.
   // Once Valid rises, Instr/InstrAddr/Valid hold until that edge; Ready
   // while Valid is low has no effect.
   modport master (
      output LoadMode, WrEn, WrData, Run, Ready, JumpEn, JumpAddr,
      input  Valid, Instr, InstrAddr, WrAddr, Halted
   );

   modport slave (
      input  LoadMode, WrEn, WrData, Run, Ready, JumpEn, JumpAddr,
      output Valid, Instr, InstrAddr, WrAddr, Halted
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction memory + program counter with a load mode and a valid/ready fetch stream.
// FETCH_WRAP_EN: defined = PC wraps after DEPTH-1; undefined = halt after the last word.
module fetch_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic             Clock,
   input  logic             Resetn,
   fetch_unit_if.slave      bus,
   output logic [1:0]       state_dbg
);
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, wr_addr, wr_addr_n, instr_addr, instr_addr_n;
   logic [DATA_W-1:0] instr, instr_n;
   logic              valid, valid_n, halted, halted_n, mem_we;
   logic [ADDR_W-1:0] jump_tgt;
   logic [DATA_W-1:0] mem [DEPTH];
`ifndef FETCH_WRAP_EN
   logic              last, last_n;
`endif

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
   endfunction

   assign jump_tgt = ADDR_W'(32'(bus.JumpAddr) % DEPTH);

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      wr_addr_n    = bus.LoadMode ? wr_addr : '0;
      instr_n      = instr;
      instr_addr_n = instr_addr;
      valid_n      = valid;
      halted_n     = halted;
      mem_we       = 1'b0;
`ifndef FETCH_WRAP_EN
      last_n       = last;
`endif
      case (state)
         IDLE: begin
            if (bus.LoadMode) begin
               if (bus.WrEn) begin
                  mem_we    = 1'b1;
                  wr_addr_n = next_addr(wr_addr);
                  halted_n  = 1'b0;
               end
            end else if (bus.Run && !halted) begin
               state_n = FETCH;
            end
         end
         FETCH, HOLD: begin
            if (bus.LoadMode) begin
               // Load request aborts the run; the next run restarts at 0.
               state_n = IDLE;
               valid_n = 1'b0;
               pc_n    = '0;
`ifndef FETCH_WRAP_EN
               last_n  = 1'b0;
`endif
            end else if (state == FETCH) begin
               instr_n      = mem[pc];
               instr_addr_n = pc;
               valid_n      = 1'b1;
               pc_n         = next_addr(pc);
`ifndef FETCH_WRAP_EN
               last_n       = (pc == LAST_ADDR);
`endif
               state_n      = HOLD;
            end else if (bus.Ready) begin
               valid_n = 1'b0;
               state_n = bus.Run ? FETCH : IDLE;
`ifndef FETCH_WRAP_EN
               last_n  = 1'b0;
`endif
               if (bus.JumpEn) begin
                  pc_n = jump_tgt;
`ifndef FETCH_WRAP_EN
               end else if (last) begin
                  state_n  = IDLE;
                  halted_n = 1'b1;
`endif
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state      <= IDLE;
         pc         <= '0;
         wr_addr    <= '0;
         instr      <= '0;
         instr_addr <= '0;
         valid      <= 1'b0;
         halted     <= 1'b0;
`ifndef FETCH_WRAP_EN
         last       <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         wr_addr    <= wr_addr_n;
         instr      <= instr_n;
         instr_addr <= instr_addr_n;
         valid      <= valid_n;
         halted     <= halted_n;
`ifndef FETCH_WRAP_EN
         last       <= last_n;
`endif
      end
   end

   // Memory has no reset so a program survives a reset.
   always_ff @(posedge Clock) begin
      if (Resetn && mem_we) mem[wr_addr] <= bus.WrData;
   end

   assign bus.Valid     = valid;
   assign bus.Instr     = instr;
   assign bus.InstrAddr = instr_addr;
   assign bus.WrAddr    = wr_addr;
   assign bus.Halted    = halted;
   assign state_dbg     = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for load/stream/jump/backpressure,
// hand sequences for abort, end-of-program (wrap or halt) and reset.
module tb_fetch_unit;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
   localparam int QW     = ADDR_W + DATA_W;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   typedef struct {
      logic              lm, we;
      logic [DATA_W-1:0] wd;
      logic              run, rdy, je;
      logic [ADDR_W-1:0] ja;
      logic              v;
      logic [DATA_W-1:0] ins;
      logic [ADDR_W-1:0] ia, wa;
      logic              h;
      logic [1:0]        st;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] state_dbg;
   always #5 clk = ~clk;

   fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .Clock     (clk),
      .Resetn    (resetn),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   int checks = 0;
   int errors = 0;
   logic [QW-1:0] exp_q[$];
   vec_t vecs[$];

   function automatic logic [DATA_W-1:0] word_at(input int a);
      return DATA_W'((a + 1) * 32'h1111);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic lm, we, input logic [DATA_W-1:0] wd,
                        input logic run, rdy, je, input logic [ADDR_W-1:0] ja);
      bus.LoadMode = lm;
      bus.WrEn     = we;
      bus.WrData   = wd;
      bus.Run      = run;
      bus.Ready    = rdy;
      bus.JumpEn   = je;
      bus.JumpAddr = ja;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic v, input logic [DATA_W-1:0] ins,
                             input logic [ADDR_W-1:0] ia, wa, input logic h, input logic [1:0] st);
      check({tag, ".valid"},  32'(bus.Valid),     32'(v));
      check({tag, ".instr"},  32'(bus.Instr),     32'(ins));
      check({tag, ".iaddr"},  32'(bus.InstrAddr), 32'(ia));
      check({tag, ".waddr"},  32'(bus.WrAddr),    32'(wa));
      check({tag, ".halted"}, 32'(bus.Halted),    32'(h));
      check({tag, ".state"},  32'(state_dbg),     32'(st));
   endtask

   task automatic add_vec(input logic lm, we, input logic [DATA_W-1:0] wd,
                          input logic run, rdy, je, input logic [ADDR_W-1:0] ja,
                          input logic v, input logic [DATA_W-1:0] ins,
                          input logic [ADDR_W-1:0] ia, wa, input logic [1:0] st);
      vec_t x;
      x.lm = lm; x.we = we; x.wd = wd; x.run = run; x.rdy = rdy; x.je = je; x.ja = ja;
      x.v = v; x.ins = ins; x.ia = ia; x.wa = wa; x.h = 1'b0; x.st = st;
      vecs.push_back(x);
   endtask

   // ---------------- scoreboard ----------------
   task automatic push_exp(input int a);
      exp_q.push_back({ADDR_W'(a), word_at(a)});
   endtask

   // Run=1, Ready=1: every Valid seen is one transfer, matched against exp_q.
   task automatic stream_check(input int budget);
      logic [QW-1:0] e;
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
      for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
         step();
         if (bus.Valid) begin
            e = exp_q.pop_front();
            check("stream.iaddr", 32'(bus.InstrAddr), 32'(e[QW-1:DATA_W]));
            check("stream.instr", 32'(bus.Instr),     32'(e[DATA_W-1:0]));
         end
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL stream.timeout: got %0d words outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   int nvalid;

   initial begin
      // Load all words; WrAddr wraps to 0 after the last one.
      for (int i = 0; i < DEPTH; i++)
         add_vec(1, 1, word_at(i), 0, 0, 0, '0, 0, '0, '0, ADDR_W'((i + 1) % DEPTH), S_IDLE);
      add_vec(0, 0, '0, 0, 0, 0, '0, 0, '0,         '0, '0, S_IDLE);
      add_vec(0, 0, '0, 1, 1, 0, '0, 0, '0,         '0, '0, S_FETCH);
      add_vec(0, 0, '0, 1, 1, 0, '0, 1, word_at(0), 0,  '0, S_HOLD);
      add_vec(0, 0, '0, 1, 1, 0, '0, 0, word_at(0), 0,  '0, S_FETCH);
      add_vec(0, 0, '0, 1, 1, 0, '0, 1, word_at(1), 1,  '0, S_HOLD);
      add_vec(0, 0, '0, 1, 1, 1, 7,  0, word_at(1), 1,  '0, S_FETCH);
      add_vec(0, 0, '0, 1, 1, 0, '0, 1, word_at(7), 7,  '0, S_HOLD);
      add_vec(0, 0, '0, 1, 0, 0, '0, 1, word_at(7), 7,  '0, S_HOLD);
      add_vec(0, 0, '0, 1, 0, 1, 3,  1, word_at(7), 7,  '0, S_HOLD);
      add_vec(0, 0, '0, 1, 0, 0, '0, 1, word_at(7), 7,  '0, S_HOLD);
      add_vec(0, 0, '0, 0, 0, 0, '0, 1, word_at(7), 7,  '0, S_HOLD);
      add_vec(0, 0, '0, 0, 0, 0, '0, 1, word_at(7), 7,  '0, S_HOLD);
      add_vec(0, 0, '0, 0, 1, 0, '0, 0, word_at(7), 7,  '0, S_IDLE);
      add_vec(0, 0, '0, 0, 1, 0, '0, 0, word_at(7), 7,  '0, S_IDLE);

      drive(0, 0, '0, 0, 0, 0, '0);
      resetn = 1'b0;
      step();
      step();
      check_outs("reset", 0, '0, '0, '0, 0, S_IDLE);
      resetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].lm, vecs[i].we, vecs[i].wd, vecs[i].run, vecs[i].rdy, vecs[i].je, vecs[i].ja);
         step();
         check_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].ins, vecs[i].ia, vecs[i].wa,
                    vecs[i].h, vecs[i].st);
      end

      // Abort during HOLD; the earlier ignored jump leaves PC at 8.
      drive(0, 0, '0, 1, 0, 0, '0);
      step();
      check("abort.fetch_state", 32'(state_dbg), 32'(S_FETCH));
      step();
      check("abort.pre_valid", 32'(bus.Valid), 32'd1);
      check("abort.pre_iaddr", 32'(bus.InstrAddr), 32'd8);
      check("abort.pre_instr", 32'(bus.Instr), 32'(word_at(8)));
      drive(1, 0, '0, 1, 0, 0, '0);
      step();
      check("abort.valid", 32'(bus.Valid), 32'd0);
      check("abort.state", 32'(state_dbg), 32'(S_IDLE));
      check("abort.waddr", 32'(bus.WrAddr), 32'd0);
      drive(0, 0, '0, 1, 0, 0, '0);
      step();
      step();
      check("restart.valid", 32'(bus.Valid), 32'd1);
      check("restart.iaddr", 32'(bus.InstrAddr), 32'd0);
      check("restart.instr", 32'(bus.Instr), 32'(word_at(0)));

      // Jump near the top and stream through the last address.
      drive(0, 0, '0, 1, 1, 1, 5'd30);
      step();
      check("jump30.state", 32'(state_dbg), 32'(S_FETCH));
      push_exp(30);
      push_exp(31);
`ifdef FETCH_WRAP_EN
      push_exp(0);
`endif
      stream_check(30);
`ifdef FETCH_WRAP_EN
      step();
      check("wrap.halted", 32'(bus.Halted), 32'd0);
      check("wrap.state", 32'(state_dbg), 32'(S_FETCH));
      step();
      check("wrap.iaddr", 32'(bus.InstrAddr), 32'd1);
      check("wrap.valid", 32'(bus.Valid), 32'd1);
`else
      step();
      check("halt.halted", 32'(bus.Halted), 32'd1);
      check("halt.state", 32'(state_dbg), 32'(S_IDLE));
      check("halt.valid", 32'(bus.Valid), 32'd0);
      nvalid = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (bus.Valid) nvalid++;
      end
      check("halt.no_valid", 32'(nvalid), 32'd0);
      drive(1, 1, word_at(0), 0, 0, 0, '0);
      step();
      check("halt.clear", 32'(bus.Halted), 32'd0);
      check("halt.clear_waddr", 32'(bus.WrAddr), 32'd1);
      drive(0, 0, '0, 1, 0, 0, '0);
      step();
      step();
      check("halt.resume_valid", 32'(bus.Valid), 32'd1);
      check("halt.resume_iaddr", 32'(bus.InstrAddr), 32'd0);
      check("halt.resume_instr", 32'(bus.Instr), 32'(word_at(0)));
`endif

      // Reset mid-stream, then confirm memory still holds the program.
      drive(0, 0, '0, 1, 0, 0, '0);
      step();
      check("midreset.pre_valid", 32'(bus.Valid), 32'd1);
      resetn = 1'b0;
      step();
      check_outs("midreset", 0, '0, '0, '0, 0, S_IDLE);
      resetn = 1'b1;
      push_exp(0);
      push_exp(1);
      push_exp(2);
      stream_check(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
